// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding,
// datapath widths and the writeback control bubble.
package mem_access_stage_pkg;

   localparam int WORD_W     = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
   } wb_ctrl_t;

   localparam wb_ctrl_t WB_BUBBLE = '{mem_to_reg: 1'b0, reg_write: 1'b0};

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage
// (master) and a variable-latency data memory (slave).
interface mem_access_stage_if;
   import mem_access_stage_pkg::*;

   logic              dmem_req;
   logic              dmem_we;
   logic [WORD_W-1:0] dmem_addr;
   logic [WORD_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [WORD_W-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register; data fields always capture, the WB control
// pair is replaced by a bubble when bubble_i is set.
module mem_wb_register
   import mem_access_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  bubble_i,
   input  logic [WORD_W-1:0]     read_data_i,
   input  logic [WORD_W-1:0]     alu_result_i,
   input  logic [REG_ADDR_W-1:0] reg_dest_i,
   input  wb_ctrl_t              wb_ctrl_i,
   output logic [WORD_W-1:0]     read_data_o,
   output logic [WORD_W-1:0]     alu_result_o,
   output logic [REG_ADDR_W-1:0] reg_dest_o,
   output wb_ctrl_t              wb_ctrl_o
);

   logic [WORD_W-1:0]     read_data_q;
   logic [WORD_W-1:0]     alu_result_q;
   logic [REG_ADDR_W-1:0] reg_dest_q;
   wb_ctrl_t              wb_ctrl_q;
   wb_ctrl_t              wb_ctrl_d;

   always_comb begin
      wb_ctrl_d = bubble_i ? WB_BUBBLE : wb_ctrl_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         read_data_q  <= '0;
         alu_result_q <= '0;
         reg_dest_q   <= '0;
         wb_ctrl_q    <= WB_BUBBLE;
      end else begin
         read_data_q  <= read_data_i;
         alu_result_q <= alu_result_i;
         reg_dest_q   <= reg_dest_i;
         wb_ctrl_q    <= wb_ctrl_d;
      end
   end

   assign read_data_o  = read_data_q;
   assign alu_result_o = alu_result_q;
   assign reg_dest_o   = reg_dest_q;
   assign wb_ctrl_o    = wb_ctrl_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues data-memory requests for loads and
// stores, stalls upstream until ack or timeout, and feeds the MEM/WB register.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access outstanding; a new request may be acked same cycle
// ST_WAIT | request outstanding, upstream stalled, counting un-acked cycles
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [WORD_W-1:0]     MEM_ALUresult,
   input  logic [WORD_W-1:0]     MEM_ReadData2,
   input  logic [REG_ADDR_W-1:0] MEM_RegDest,
   input  logic                  MEM_MemRead,
   input  logic                  MEM_MemWrite,
   input  logic                  MEM_MemtoReg,
   input  logic                  MEM_RegWrite,

   mem_access_stage_if.master    dmem,

   output logic                  mem_stall,
   input  logic                  err_clr,

   output logic [WORD_W-1:0]     MEMtoWB_ReadData,
   output logic [WORD_W-1:0]     MEMtoWB_ALUresult,
   output logic [REG_ADDR_W-1:0] MEMtoWB_RegDest,
   output logic                  WB_MemtoReg,
   output logic                  WB_RegWrite,
   output logic                  mem_timeout,
   output logic                  mem_misaligned
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             misal_flag_q, misal_flag_d;

   logic access, misal, req, unacked, abort, stall, bubble;
   wb_ctrl_t wb_ctrl_in, wb_ctrl_out;

   assign access  = MEM_MemRead | MEM_MemWrite;
   assign misal   = access & (MEM_ALUresult[1:0] != 2'b00);
   assign req     = ~rst & access & ~misal;
   assign unacked = req & ~dmem.dmem_ack;
   assign abort   = unacked & (cnt_q == CNT_LAST);
   assign stall   = unacked & ~abort;
   // A misaligned access or any un-acked cycle (stall or abort) must not reach WB.
   assign bubble  = misal | unacked;

   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      timeout_d    = abort | (timeout_q & ~err_clr);
      misal_flag_d = misal | (misal_flag_q & ~err_clr);
      case (state_q)
         ST_IDLE: if (stall)  state_d = ST_WAIT;
         ST_WAIT: if (!stall) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (stall) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
         misal_flag_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
         misal_flag_q <= misal_flag_d;
      end
   end

   assign dmem.dmem_req   = req;
   assign dmem.dmem_we    = MEM_MemWrite;
   assign dmem.dmem_addr  = MEM_ALUresult;
   assign dmem.dmem_wdata = MEM_ReadData2;

   assign mem_stall      = stall;
   assign mem_timeout    = timeout_q;
   assign mem_misaligned = misal_flag_q;

   assign wb_ctrl_in = '{mem_to_reg: MEM_MemtoReg, reg_write: MEM_RegWrite};

   mem_wb_register u_mem_wb (
      .clk          (clk),
      .rst          (rst),
      .bubble_i     (bubble),
      .read_data_i  (dmem.dmem_rdata),
      .alu_result_i (MEM_ALUresult),
      .reg_dest_i   (MEM_RegDest),
      .wb_ctrl_i    (wb_ctrl_in),
      .read_data_o  (MEMtoWB_ReadData),
      .alu_result_o (MEMtoWB_ALUresult),
      .reg_dest_o   (MEMtoWB_RegDest),
      .wb_ctrl_o    (wb_ctrl_out)
   );

   assign WB_MemtoReg = wb_ctrl_out.mem_to_reg;
   assign WB_RegWrite = wb_ctrl_out.reg_write;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus randomized transactions
// checked against a cycle-level behavioural model.
module tb_mem_access_stage;
   import mem_access_stage_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] MEM_ALUresult, MEM_ReadData2;
   logic [4:0]  MEM_RegDest;
   logic        MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite;
   logic        mem_stall, err_clr;
   logic [31:0] MEMtoWB_ReadData, MEMtoWB_ALUresult;
   logic [4:0]  MEMtoWB_RegDest;
   logic        WB_MemtoReg, WB_RegWrite, mem_timeout, mem_misaligned;

   int checks = 0;
   int failures = 0;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk               (clk),
      .rst               (rst),
      .MEM_ALUresult     (MEM_ALUresult),
      .MEM_ReadData2     (MEM_ReadData2),
      .MEM_RegDest       (MEM_RegDest),
      .MEM_MemRead       (MEM_MemRead),
      .MEM_MemWrite      (MEM_MemWrite),
      .MEM_MemtoReg      (MEM_MemtoReg),
      .MEM_RegWrite      (MEM_RegWrite),
      .dmem              (bus.master),
      .mem_stall         (mem_stall),
      .err_clr           (err_clr),
      .MEMtoWB_ReadData  (MEMtoWB_ReadData),
      .MEMtoWB_ALUresult (MEMtoWB_ALUresult),
      .MEMtoWB_RegDest   (MEMtoWB_RegDest),
      .WB_MemtoReg       (WB_MemtoReg),
      .WB_RegWrite       (WB_RegWrite),
      .mem_timeout       (mem_timeout),
      .mem_misaligned    (mem_misaligned)
   );

   always #5 clk = ~clk;

   // behavioural model of the registered outputs
   logic [31:0] m_rdata, m_alu;
   logic [4:0]  m_dest;
   logic        m_m2r, m_rw, m_to, m_mis;
   int          m_waited;

   task automatic set_instr(input logic rd, input logic wr, input logic m2r, input logic rw,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest);
      MEM_MemRead = rd; MEM_MemWrite = wr; MEM_MemtoReg = m2r; MEM_RegWrite = rw;
      MEM_ALUresult = alu; MEM_ReadData2 = wd; MEM_RegDest = dest;
   endtask

   // Drives one cycle, samples the combinational outputs mid-cycle, advances the model.
   task automatic run_cycle(input logic ack_v, input logic [31:0] rdata_v, input logic clr_v,
                            output logic o_req, output logic o_stall, output logic o_we,
                            output logic e_req, output logic e_stall);
      logic acc, mis, rq, unack, abrt, stl;
      bus.dmem_ack = ack_v; bus.dmem_rdata = rdata_v; err_clr = clr_v;
      #1;
      o_req = bus.dmem_req; o_stall = mem_stall; o_we = bus.dmem_we;
      acc   = MEM_MemRead || MEM_MemWrite;
      mis   = acc && (MEM_ALUresult % 4 != 0);
      rq    = !rst && acc && !mis;
      unack = rq && !ack_v;
      abrt  = unack && (m_waited == TO - 1);
      stl   = unack && !abrt;
      e_req = rq; e_stall = stl;
      @(posedge clk);
      if (rst) begin
         m_rdata = 0; m_alu = 0; m_dest = 0; m_m2r = 0; m_rw = 0;
         m_to = 0; m_mis = 0; m_waited = 0;
      end else begin
         m_rdata = rdata_v; m_alu = MEM_ALUresult; m_dest = MEM_RegDest;
         m_m2r = (mis || unack) ? 1'b0 : MEM_MemtoReg;
         m_rw  = (mis || unack) ? 1'b0 : MEM_RegWrite;
         m_waited = stl ? m_waited + 1 : 0;
         m_to  = abrt || (m_to && !clr_v);
         m_mis = mis || (m_mis && !clr_v);
      end
      #1;
   endtask

   task automatic test_reset();
      logic o_req, o_stall, o_we, e_req, e_stall;
      rst = 1'b1;
      set_instr(1, 0, 1, 1, 32'h10, 32'h0, 5'd3);
      run_cycle(1'b0, 32'h5555_aaaa, 1'b0, o_req, o_stall, o_we, e_req, e_stall);
      checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", o_req); end
      checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", o_stall); end
      checks++; if (MEMtoWB_ReadData !== 32'h0 || MEMtoWB_ALUresult !== 32'h0 || MEMtoWB_RegDest !== 5'h0) begin
         failures++; $display("FAIL reset_data: got %h %h %h want 0", MEMtoWB_ReadData, MEMtoWB_ALUresult, MEMtoWB_RegDest); end
      checks++; if ({WB_MemtoReg, WB_RegWrite, mem_timeout, mem_misaligned} !== 4'b0) begin
         failures++; $display("FAIL reset_ctrl: got %b%b%b%b want 0000", WB_MemtoReg, WB_RegWrite, mem_timeout, mem_misaligned); end
      rst = 1'b0;
   endtask

   task automatic test_alu_pass();
      logic o_req, o_stall, o_we, e_req, e_stall;
      set_instr(0, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd5);
      run_cycle(1'b0, 32'h0, 1'b0, o_req, o_stall, o_we, e_req, e_stall);
      checks++; if (o_req !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL alu_req_stall: got %b%b want 00", o_req, o_stall); end
      checks++; if (MEMtoWB_ALUresult !== 32'h1234) begin failures++; $display("FAIL alu_result: got %h want 00001234", MEMtoWB_ALUresult); end
      checks++; if (MEMtoWB_RegDest !== 5'd5 || WB_RegWrite !== 1'b1) begin
         failures++; $display("FAIL alu_wb: got dest=%0d rw=%b want dest=5 rw=1", MEMtoWB_RegDest, WB_RegWrite); end
   endtask

   task automatic test_load_zero_wait();
      logic o_req, o_stall, o_we, e_req, e_stall;
      set_instr(1, 0, 1, 1, 32'h100, 32'h0, 5'd7);
      run_cycle(1'b1, 32'hDEAD_BEEF, 1'b0, o_req, o_stall, o_we, e_req, e_stall);
      checks++; if (o_req !== 1'b1 || o_stall !== 1'b0 || o_we !== 1'b0) begin
         failures++; $display("FAIL load0_handshake: got req=%b stall=%b we=%b want 1 0 0", o_req, o_stall, o_we); end
      checks++; if (bus.dmem_addr !== 32'h100) begin failures++; $display("FAIL load0_addr: got %h want 00000100", bus.dmem_addr); end
      checks++; if (MEMtoWB_ReadData !== 32'hDEAD_BEEF || WB_MemtoReg !== 1'b1 || WB_RegWrite !== 1'b1) begin
         failures++; $display("FAIL load0_wb: got %h m2r=%b rw=%b want deadbeef 1 1", MEMtoWB_ReadData, WB_MemtoReg, WB_RegWrite); end
   endtask

   task automatic test_store_wait();
      logic o_req, o_stall, o_we, e_req, e_stall;
      int n_req = 0, n_we = 0, n_stall = 0, n_rw = 0;
      set_instr(0, 1, 0, 0, 32'h200, 32'hCAFE_0001, 5'd0);
      for (int k = 0; k < 4; k++) begin
         run_cycle(k == 3, 32'h0, 1'b0, o_req, o_stall, o_we, e_req, e_stall);
         if (o_req === 1'b1) n_req++;
         if (o_req === 1'b1 && o_we === 1'b1) n_we++;
         if (o_stall === 1'b1) n_stall++;
         if (WB_RegWrite !== 1'b0) n_rw++;
      end
      checks++; if (n_req != 4 || n_we != 4) begin failures++; $display("FAIL store_req: got req=%0d we=%0d want 4 4", n_req, n_we); end
      checks++; if (n_stall != 3) begin failures++; $display("FAIL store_stall: got %0d want 3", n_stall); end
      checks++; if (n_rw != 0) begin failures++; $display("FAIL store_rw: got %0d cycles with RegWrite want 0", n_rw); end
      checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL store_state: got %b want IDLE", dut.state_q); end
   endtask

   task automatic test_timeout();
      logic o_req, o_stall, o_we, e_req, e_stall;
      int n_stall = 0;
      logic last_req = 1'b0;
      logic ended = 1'b0;
      set_instr(1, 0, 1, 1, 32'h300, 32'h0, 5'd9);
      for (int k = 0; k < 40 && !ended; k++) begin
         run_cycle(1'b0, 32'h0, 1'b0, o_req, o_stall, o_we, e_req, e_stall);
         if (o_stall === 1'b1) n_stall++;
         else begin ended = 1'b1; last_req = o_req; end
      end
      checks++; if (!ended || n_stall != TO - 1) begin
         failures++; $display("FAIL timeout_stall_len: got %0d ended=%b want %0d", n_stall, ended, TO - 1); end
      checks++; if (last_req !== 1'b1) begin failures++; $display("FAIL timeout_abort_req: got %b want 1", last_req); end
      checks++; if (mem_timeout !== 1'b1 || WB_RegWrite !== 1'b0) begin
         failures++; $display("FAIL timeout_flag: got to=%b rw=%b want 1 0", mem_timeout, WB_RegWrite); end
      set_instr(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      run_cycle(1'b0, 32'h0, 1'b1, o_req, o_stall, o_we, e_req, e_stall);
      checks++; if (mem_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b want 0", mem_timeout); end
   endtask

   task automatic test_misaligned();
      logic o_req, o_stall, o_we, e_req, e_stall;
      set_instr(1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd4);
      run_cycle(1'b0, 32'h0, 1'b1, o_req, o_stall, o_we, e_req, e_stall);
      checks++; if (o_req !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL misal_req_stall: got %b%b want 00", o_req, o_stall); end
      checks++; if (mem_misaligned !== 1'b1) begin failures++; $display("FAIL misal_set_wins: got %b want 1", mem_misaligned); end
      checks++; if (WB_RegWrite !== 1'b0 || WB_MemtoReg !== 1'b0) begin
         failures++; $display("FAIL misal_bubble: got rw=%b m2r=%b want 0 0", WB_RegWrite, WB_MemtoReg); end
      set_instr(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      run_cycle(1'b0, 32'h0, 1'b1, o_req, o_stall, o_we, e_req, e_stall);
      checks++; if (mem_misaligned !== 1'b0) begin failures++; $display("FAIL misal_clear: got %b want 0", mem_misaligned); end
   endtask

   task automatic test_reset_mid_access();
      logic o_req, o_stall, o_we, e_req, e_stall;
      set_instr(1, 0, 1, 1, 32'h400, 32'h0, 5'd11);
      run_cycle(1'b0, 32'h1111_2222, 1'b0, o_req, o_stall, o_we, e_req, e_stall);
      rst = 1'b1;
      run_cycle(1'b0, 32'h3333_4444, 1'b0, o_req, o_stall, o_we, e_req, e_stall);
      checks++; if (o_req !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL rstmid_req_stall: got %b%b want 00", o_req, o_stall); end
      checks++; if (MEMtoWB_ALUresult !== 32'h0 || MEMtoWB_ReadData !== 32'h0 || mem_timeout !== 1'b0) begin
         failures++; $display("FAIL rstmid_outputs: got alu=%h rd=%h to=%b want 0", MEMtoWB_ALUresult, MEMtoWB_ReadData, mem_timeout); end
      checks++; if (dut.state_q !== ST_IDLE || dut.cnt_q !== '0) begin
         failures++; $display("FAIL rstmid_fsm: got state=%b cnt=%0d want IDLE 0", dut.state_q, dut.cnt_q); end
      rst = 1'b0;
      set_instr(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      run_cycle(1'b1, 32'h0, 1'b0, o_req, o_stall, o_we, e_req, e_stall);
      checks++; if (o_stall !== 1'b0 || dut.state_q !== ST_IDLE || mem_timeout !== 1'b0) begin
         failures++; $display("FAIL stray_ack: got stall=%b state=%b to=%b want 0 IDLE 0", o_stall, dut.state_q, mem_timeout); end
   endtask

   task automatic test_random();
      logic o_req, o_stall, o_we, e_req, e_stall;
      for (int t = 0; t < 60; t++) begin
         int kind, lat;
         logic rd, wr, done;
         logic [31:0] alu;
         kind = $urandom_range(0, 3);
         rd = (kind == 1 || kind == 3);
         wr = (kind >= 2);
         alu = $urandom;
         alu[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         set_instr(rd, wr, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom));
         lat = $urandom_range(0, 20);
         done = 1'b0;
         for (int k = 0; k < 40 && !done; k++) begin
            logic ack;
            ack = (rd || wr) ? (k == lat) : 1'($urandom);
            run_cycle(ack, $urandom, $urandom_range(0, 7) == 0, o_req, o_stall, o_we, e_req, e_stall);
            checks++; if (o_req !== e_req || o_stall !== e_stall) begin
               failures++; $display("FAIL rand_handshake t=%0d k=%0d: got req=%b stall=%b want %b %b", t, k, o_req, o_stall, e_req, e_stall); end
            if (e_req) begin
               checks++; if (o_we !== wr) begin failures++; $display("FAIL rand_we t=%0d: got %b want %b", t, o_we, wr); end
            end
            checks++; if (MEMtoWB_ReadData !== m_rdata || MEMtoWB_ALUresult !== m_alu || MEMtoWB_RegDest !== m_dest) begin
               failures++; $display("FAIL rand_data t=%0d k=%0d: got %h %h %h want %h %h %h", t, k,
                  MEMtoWB_ReadData, MEMtoWB_ALUresult, MEMtoWB_RegDest, m_rdata, m_alu, m_dest); end
            checks++; if ({WB_MemtoReg, WB_RegWrite, mem_timeout, mem_misaligned} !== {m_m2r, m_rw, m_to, m_mis}) begin
               failures++; $display("FAIL rand_ctrl t=%0d k=%0d: got %b%b%b%b want %b%b%b%b", t, k,
                  WB_MemtoReg, WB_RegWrite, mem_timeout, mem_misaligned, m_m2r, m_rw, m_to, m_mis); end
            if (!e_stall) done = 1'b1;
         end
         checks++; if (!done) begin failures++; $display("FAIL rand_bound t=%0d: got still stalled want done", t); end
      end
   endtask

   initial begin
      m_rdata = 0; m_alu = 0; m_dest = 0; m_m2r = 0; m_rw = 0;
      m_to = 0; m_mis = 0; m_waited = 0;
      rst = 1'b1; err_clr = 1'b0;
      bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
      set_instr(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      test_reset();
      test_alu_pass();
      test_load_zero_wait();
      test_store_wait();
      test_timeout();
      test_misaligned();
      test_reset_mid_access();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
